// File: rtl/sbit_rate_monitor_pkg.sv
// ---------------------------------------------------------------------------
// sbit_monitor_pkg
// Shared sizing constants, FSM state encoding and small helpers for the
// per-VFAT S-bit rate monitor (sbit_rate_monitor and its sub-blocks).
// No ports: package only.
// ---------------------------------------------------------------------------
package sbit_monitor_pkg;

  localparam int MXVFATS   = 24;
  localparam int MXSBITS   = 64;
  localparam int CNT_BITS  = 24;
  localparam int GATE_BITS = 32;
  localparam int SEL_BITS  = 5;

  // VFAT count expressed in the width of the readout select
  localparam logic [SEL_BITS-1:0]  MXVFATS_SEL = SEL_BITS'(MXVFATS);
  localparam logic [GATE_BITS-1:0] GATE_ONE    = {{(GATE_BITS-1){1'b0}}, 1'b1};
  localparam logic [GATE_BITS-1:0] GATE_ZERO   = {GATE_BITS{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_LATCH = 2'd3
  } mon_state_e;

  // A zero-length gate would never reach the "last cycle" condition, so it
  // is promoted to a single-clock window.
  function automatic logic [GATE_BITS-1:0] gate_floor(input logic [GATE_BITS-1:0] len);
    logic [GATE_BITS-1:0] res;
    if (len == GATE_ZERO) begin
      res = GATE_ONE;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/sbit_rate_monitor_if.sv
// ---------------------------------------------------------------------------
// sbit_rate_monitor_if
// Bundles the aligned S-bit bus, the measurement controls and the slow-control
// readout of the rate monitor.
//   master : trigger/slow-control side (drives S-bits, mask, gate, start,
//            continuous, sel_vfat; receives rate/overflow/busy/done)
//   slave  : the monitor itself
// Parameter CNT_BITS sets the width of the rate readout.
// ---------------------------------------------------------------------------
interface sbit_rate_monitor_if #(
  parameter int CNT_BITS = sbit_monitor_pkg::CNT_BITS
);
  import sbit_monitor_pkg::*;

  logic [MXVFATS*MXSBITS-1:0] sbits;
  logic [MXVFATS-1:0]         sbit_mask;
  logic [GATE_BITS-1:0]       gate_length;
  logic                       start_i;
  logic                       continuous_i;
  logic [SEL_BITS-1:0]        sel_vfat;
  logic [CNT_BITS-1:0]        rate_o;
  logic                       overflow_o;
  logic                       busy_o;
  logic                       done_o;

  modport master (
    output sbits, sbit_mask, gate_length, start_i, continuous_i, sel_vfat,
    input  rate_o, overflow_o, busy_o, done_o
  );

  modport slave (
    input  sbits, sbit_mask, gate_length, start_i, continuous_i, sel_vfat,
    output rate_o, overflow_o, busy_o, done_o
  );

endinterface

// File: rtl/sbit_rate_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// WIDTH-bit up counter that saturates at all-ones instead of wrapping.
// An increment attempted while saturated sets a sticky overflow flag.
// Ports:
//   clock    : fabric clock
//   reset_i  : synchronous active-low reset
//   clr_i    : clear count and overflow (wins over en_i)
//   en_i     : increment request
//   count_o  : current count
//   ovf_o    : overflow flag
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             ovf_o
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      count_d = CNT_ZERO;
      ovf_d   = 1'b0;
    end else if (en_i) begin
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter and flag registers
  always_ff @(posedge clock) begin
    if (!reset_i) begin
      count_q <= CNT_ZERO;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/sbit_rate_monitor.sv
// ---------------------------------------------------------------------------
// sbit_rate_monitor
// Counts, over a programmable gate window, the clocks in which each VFAT has
// any unmasked S-bit set. Results are latched per VFAT at the end of each
// window and read back one VFAT at a time.
// Ports:
//   clock    : 40 MHz fabric clock (same domain as aligned S-bits)
//   reset_i  : synchronous active-low reset
//   bus      : sbit_rate_monitor_if.slave (S-bits, mask, gate_length,
//              start_i, continuous_i, sel_vfat in; rate_o, overflow_o,
//              busy_o, done_o out; all outputs registered)
// Timing: start accepted at edge E0 -> ARM at E0+1 -> G COUNT edges ->
// LATCH edge E0+G+2, where done_o rises together with the new results.
// ---------------------------------------------------------------------------
module sbit_rate_monitor #(
  parameter int CNT_BITS = sbit_monitor_pkg::CNT_BITS
) (
  input  logic                clock,
  input  logic                reset_i,
  sbit_rate_monitor_if.slave  bus
);
  import sbit_monitor_pkg::*;

  mon_state_e           state_q, state_d;
  logic [GATE_BITS-1:0] glen_q, glen_d;
  logic [GATE_BITS-1:0] gate_q, gate_d;
  logic [MXVFATS-1:0]   hit_q, hit_d;
  logic                 arm_s, count_s, latch_s;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CNT_BITS-1:0]  cnt_s [MXVFATS];
  logic [MXVFATS-1:0]   ovf_s;
  logic [CNT_BITS-1:0]  lat_rate_q [MXVFATS];
  logic [MXVFATS-1:0]   lat_ovf_q;
  logic [CNT_BITS-1:0]  rate_q, rate_d;
  logic                 ovf_q, ovf_d;

  // Stage-1 hit: any S-bit of a VFAT, gated by its mask bit
  always_comb begin
    hit_d = {MXVFATS{1'b0}};
    for (int v = 0; v < MXVFATS; v++) begin
      hit_d[v] = (|bus.sbits[v*MXSBITS +: MXSBITS]) & ~bus.sbit_mask[v];
    end
  end

  // Stage-1 hit register, sampled every clock regardless of FSM state
  always_ff @(posedge clock) begin
    if (!reset_i) begin
      hit_q <= {MXVFATS{1'b0}};
    end else begin
      hit_q <= hit_d;
    end
  end

  // FSM next state, gate counter and per-state strobes
  always_comb begin
    state_d = state_q;
    glen_d  = glen_q;
    gate_d  = gate_q;
    arm_s   = 1'b0;
    count_s = 1'b0;
    latch_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          glen_d  = gate_floor(bus.gate_length);
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        arm_s   = 1'b1;
        gate_d  = glen_q;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        // hit_q lags sbits by one edge, so COUNT edges E1+1..E1+G
        // accumulate the samples taken at E1..E1+G-1
        count_s = 1'b1;
        if (gate_q == GATE_ONE) begin
          state_d = ST_LATCH;
        end else begin
          gate_d  = gate_q - GATE_ONE;
          state_d = ST_COUNT;
        end
      end
      ST_LATCH: begin
        latch_s = 1'b1;
        if (bus.continuous_i) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = latch_s;
  end

  // FSM, gate and status registers
  always_ff @(posedge clock) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      glen_q  <= GATE_ZERO;
      gate_q  <= GATE_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      glen_q  <= glen_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // One saturating counter per VFAT; ARM clears, COUNT accumulates hits
  for (genvar v = 0; v < MXVFATS; v++) begin : g_cnt
    sat_counter #(.WIDTH(CNT_BITS)) u_cnt (
      .clock   (clock),
      .reset_i (reset_i),
      .clr_i   (arm_s),
      .en_i    (count_s & hit_q[v]),
      .count_o (cnt_s[v]),
      .ovf_o   (ovf_s[v])
    );
  end

  // Latched result arrays, updated only on the LATCH edge
  always_ff @(posedge clock) begin
    if (!reset_i) begin
      for (int v = 0; v < MXVFATS; v++) begin
        lat_rate_q[v] <= {CNT_BITS{1'b0}};
      end
      lat_ovf_q <= {MXVFATS{1'b0}};
    end else if (latch_s) begin
      for (int v = 0; v < MXVFATS; v++) begin
        lat_rate_q[v] <= cnt_s[v];
      end
      lat_ovf_q <= ovf_s;
    end
  end

  // Readout mux; out-of-range selects read as zero
  always_comb begin
    rate_d = {CNT_BITS{1'b0}};
    ovf_d  = 1'b0;
    if (bus.sel_vfat < MXVFATS_SEL) begin
      rate_d = lat_rate_q[bus.sel_vfat];
      ovf_d  = lat_ovf_q[bus.sel_vfat];
    end else begin
      rate_d = {CNT_BITS{1'b0}};
      ovf_d  = 1'b0;
    end
  end

  // Readout registers
  always_ff @(posedge clock) begin
    if (!reset_i) begin
      rate_q <= {CNT_BITS{1'b0}};
      ovf_q  <= 1'b0;
    end else begin
      rate_q <= rate_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.rate_o     = rate_q;
  assign bus.overflow_o = ovf_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

endmodule

// File: tb/tb_sbit_rate_monitor.sv
// ---------------------------------------------------------------------------
// tb_sbit_rate_monitor
// Directed bench for sbit_rate_monitor. Two instances share one stimulus:
// "dut" with the default 24-bit counters and "dut_sat" with 4-bit counters
// for the saturation case. A window-level model (start edge, window edges,
// latch edge, plain per-VFAT hit sums) predicts the outputs of both every
// cycle; literal expectations from the directed cases pin the model.
// ---------------------------------------------------------------------------
module tb_sbit_rate_monitor;
  import sbit_monitor_pkg::*;

  logic clock;
  logic reset_i;

  sbit_rate_monitor_if #(.CNT_BITS(24)) mif ();
  sbit_rate_monitor_if #(.CNT_BITS(4))  sif ();

  sbit_rate_monitor #(.CNT_BITS(24)) dut (
    .clock   (clock),
    .reset_i (reset_i),
    .bus     (mif.slave)
  );

  sbit_rate_monitor #(.CNT_BITS(4)) dut_sat (
    .clock   (clock),
    .reset_i (reset_i),
    .bus     (sif.slave)
  );

  assign sif.sbits        = mif.sbits;
  assign sif.sbit_mask    = mif.sbit_mask;
  assign sif.gate_length  = mif.gate_length;
  assign sif.start_i      = mif.start_i;
  assign sif.continuous_i = mif.continuous_i;
  assign sif.sel_vfat     = mif.sel_vfat;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // stimulus state
  int mode       = 0;
  int phase_base = 0;

  // model state
  bit m_active = 1'b0;
  int m_e0 = 0;
  int m_g  = 0;
  int acc [MXVFATS];
  int lat [MXVFATS];
  bit x_done = 1'b0;
  bit x_busy = 1'b0;
  int x_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat_val(input int c, input int bits);
    int mx;
    mx = (1 << bits) - 1;
    return (c > mx) ? mx : c;
  endfunction

  function automatic bit hit_of(input int v);
    return (|mif.sbits[v*MXSBITS +: MXSBITS]) && !mif.sbit_mask[v];
  endfunction

  // Window-level model: which edges belong to a window, when it latches
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (!reset_i) begin
      m_active = 1'b0;
      x_done   = 1'b0;
      x_busy   = 1'b0;
      x_cnt    = 0;
      for (int v = 0; v < MXVFATS; v++) begin
        acc[v] = 0;
        lat[v] = 0;
      end
    end else begin
      x_cnt  = (mif.sel_vfat < MXVFATS) ? lat[mif.sel_vfat] : 0;
      x_done = 1'b0;
      if (m_active) begin
        if (cyc > m_e0 && cyc <= m_e0 + m_g) begin
          for (int v = 0; v < MXVFATS; v++) begin
            if (hit_of(v)) acc[v]++;
          end
        end
        if (cyc == m_e0 + m_g + 2) begin
          for (int v = 0; v < MXVFATS; v++) lat[v] = acc[v];
          x_done = 1'b1;
          if (mif.continuous_i) begin
            m_e0 = cyc;
            for (int v = 0; v < MXVFATS; v++) acc[v] = 0;
          end else begin
            m_active = 1'b0;
          end
        end
      end else if (mif.start_i) begin
        m_active = 1'b1;
        m_e0     = cyc;
        m_g      = (mif.gate_length == 0) ? 1 : int'(mif.gate_length);
        for (int v = 0; v < MXVFATS; v++) acc[v] = 0;
      end
      x_busy = m_active;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clock) begin
    if (cyc >= 1) begin
      chk("busy",     64'(mif.busy_o),     64'(x_busy));
      chk("done",     64'(mif.done_o),     64'(x_done));
      chk("rate",     64'(mif.rate_o),     64'(sat_val(x_cnt, 24)));
      chk("ovf",      64'(mif.overflow_o), 64'(x_cnt > 16777215));
      chk("sat_busy", 64'(sif.busy_o),     64'(x_busy));
      chk("sat_done", 64'(sif.done_o),     64'(x_done));
      chk("sat_rate", 64'(sif.rate_o),     64'(sat_val(x_cnt, 4)));
      chk("sat_ovf",  64'(sif.overflow_o), 64'(x_cnt > 15));
    end
  end

  // Drive S-bits for the upcoming edge from the active pattern
  task automatic drive_sbits();
    int k;
    int k12;
    k   = (cyc + 1) - phase_base;
    k12 = ((k % 12) + 12) % 12;
    mif.sbits = '0;
    case (mode)
      1: mif.sbits[3*MXSBITS + 0] = 1'b1;
      2: if ((k % 4) == 0) begin
           mif.sbits[0*MXSBITS + 63] = 1'b1;
           mif.sbits[1*MXSBITS + 17] = 1'b1;
         end
      3: mif.sbits[5*MXSBITS + 40] = 1'b1;
      4: if (k12 >= 2 && k12 <= 4) mif.sbits[7*MXSBITS + 9] = 1'b1;
      5: mif.sbits[2*MXSBITS + 5] = 1'b1;
      6: mif.sbits[0*MXSBITS + 1] = 1'b1;
      default: mif.sbits = '0;
    endcase
  endtask

  task automatic tick();
    @(negedge clock);
    drive_sbits();
  endtask

  // Pulse start for one edge; e0 is the edge that accepts it
  task automatic go(input int g, output int e0);
    @(negedge clock);
    phase_base      = cyc + 1;
    e0              = cyc + 1;
    mif.gate_length = g;
    mif.start_i     = 1'b1;
    drive_sbits();
    tick();
    mif.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (mif.done_o === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic read_sel(input int s);
    mif.sel_vfat = s[4:0];
    tick();
  endtask

  int e0;
  int at;
  int d [3];

  initial begin
    reset_i          = 1'b0;
    mif.sbits        = '0;
    mif.sbit_mask    = '0;
    mif.gate_length  = '0;
    mif.start_i      = 1'b0;
    mif.continuous_i = 1'b0;
    mif.sel_vfat     = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(mif.busy_o), 64'd0);
    chk("rst_done", 64'(mif.done_o), 64'd0);
    chk("rst_rate", 64'(mif.rate_o), 64'd0);
    reset_i = 1'b1;
    tick();

    // 1: constant hits on VFAT 3
    mode = 1; mif.sel_vfat = 5'd3;
    go(100, e0);
    wait_done(120, at);
    chk("t1_done_time", 64'(at), 64'(e0 + 102));
    tick();
    chk("t1_rate3", 64'(mif.rate_o), 64'd100);
    chk("t1_ovf3", 64'(mif.overflow_o), 64'd0);
    read_sel(4);
    chk("t1_rate4", 64'(mif.rate_o), 64'd0);

    // 2: sparse hits, VFAT 1 masked
    mode = 2; mif.sbit_mask = 24'h000002; mif.sel_vfat = 5'd0;
    go(40, e0);
    wait_done(60, at);
    chk("t2_done_time", 64'(at), 64'(e0 + 42));
    tick();
    chk("t2_rate0", 64'(mif.rate_o), 64'd10);
    read_sel(1);
    chk("t2_rate1", 64'(mif.rate_o), 64'd0);
    mif.sbit_mask = '0;

    // 3: saturation on the 4-bit instance
    mode = 3; mif.sel_vfat = 5'd5;
    go(20, e0);
    wait_done(40, at);
    chk("t3_done_time", 64'(at), 64'(e0 + 22));
    tick();
    chk("t3_sat_rate5", 64'(sif.rate_o), 64'd15);
    chk("t3_sat_ovf5", 64'(sif.overflow_o), 64'd1);
    chk("t3_rate5", 64'(mif.rate_o), 64'd20);
    read_sel(6);
    chk("t3_sat_rate6", 64'(sif.rate_o), 64'd0);
    chk("t3_sat_ovf6", 64'(sif.overflow_o), 64'd0);

    // 4: continuous mode, released during the third window
    mode = 4; mif.sel_vfat = 5'd7; mif.continuous_i = 1'b1;
    go(10, e0);
    for (int w = 0; w < 3; w++) begin
      wait_done(20, at);
      d[w] = at;
      tick();
      chk("t4_rate7", 64'(mif.rate_o), 64'd3);
      if (w == 1) begin
        repeat (3) tick();
        mif.continuous_i = 1'b0;
      end
    end
    chk("t4_first", 64'(d[0]), 64'(e0 + 12));
    chk("t4_gap1", 64'(d[1] - d[0]), 64'd12);
    chk("t4_gap2", 64'(d[2] - d[1]), 64'd12);
    chk("t4_idle", 64'(mif.busy_o), 64'd0);
    wait_done(20, at);
    chk("t4_no_extra_done", 64'(at), 64'(-1));

    // 5: full window on VFAT 2, then reset during the next window
    mode = 5; mif.sel_vfat = 5'd2;
    go(50, e0);
    wait_done(70, at);
    chk("t5_done_time", 64'(at), 64'(e0 + 52));
    tick();
    chk("t5_rate2", 64'(mif.rate_o), 64'd50);
    go(50, e0);
    repeat (4) tick();
    reset_i = 1'b0;
    repeat (2) tick();
    reset_i = 1'b1;
    wait_done(60, at);
    chk("t5_no_done", 64'(at), 64'(-1));
    chk("t5_idle", 64'(mif.busy_o), 64'd0);
    for (int s = 0; s < MXVFATS; s++) begin
      read_sel(s);
      chk("t5_rate_cleared", 64'(mif.rate_o), 64'd0);
    end

    // 6: zero gate length, start repeated while busy, out-of-range select
    mode = 6; mif.sel_vfat = 5'd0;
    @(negedge clock);
    phase_base = cyc + 1;
    e0 = cyc + 1;
    mif.gate_length = 0;
    mif.start_i = 1'b1;
    drive_sbits();
    tick();
    tick();
    mif.start_i = 1'b0;
    wait_done(10, at);
    chk("t6_done_time", 64'(at), 64'(e0 + 3));
    wait_done(10, at);
    chk("t6_single_done", 64'(at), 64'(-1));
    chk("t6_rate0", 64'(mif.rate_o), 64'd1);
    read_sel(24);
    chk("t6_rate24", 64'(mif.rate_o), 64'd0);
    chk("t6_ovf24", 64'(mif.overflow_o), 64'd0);

    mode = 0;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sbit_rate_monitor.md
Name: sbit_rate_monitor

Overview:
Per-VFAT S-bit rate monitor downstream of the trigger alignment stage. Consumes the aligned S-bit bus (MXSBITS per VFAT, 24 VFATs). Over a programmable gate window, it counts the clock cycles in which each VFAT has any unmasked S-bit set. Results are latched per VFAT and read out through a selectable register port for slow control.

Parameters:
MXVFATS, 24, number of VFATs on the aligned bus
MXSBITS, 64, S-bits per VFAT per clock (128 when alignment runs DDR)
CNT_BITS, 24, per-VFAT rate counter width
GATE_BITS, 32, gate length width

Ports:
clock  in  1  40 MHz fabric clock, same domain as aligned S-bits
reset_i  in  1  synchronous, active-low reset
sbits  in  MXVFATS*MXSBITS  aligned S-bits; VFAT v occupies [v*MXSBITS +: MXSBITS]
sbit_mask  in  MXVFATS  1 = VFAT excluded from counting
gate_length  in  GATE_BITS  window length in clocks; sampled on start
start_i  in  1  level; start a measurement when idle
continuous_i  in  1  re-arm automatically after each window
sel_vfat  in  5  VFAT index for readout
rate_o  out  CNT_BITS  latched count of sel_vfat
overflow_o  out  1  latched saturation flag of sel_vfat
busy_o  out  1  high in ARM/COUNT/LATCH
done_o  out  1  one-cycle pulse when a new result set is latched

Behaviour:
- Reset (reset_i low at an edge):
  - FSM goes to IDLE.
  - All counters, latched rates, overflow flags and the OR pipeline register are cleared.
  - rate_o=0, overflow_o=0, busy_o=0, done_o=0.
  - Reset mid-window discards the partial window; no done_o is produced.
- Stage 1 (registered): hit[v] = (|sbits[v]) & ~sbit_mask[v], captured every clock.
- FSM states: IDLE, ARM, COUNT, LATCH.
- IDLE:
  - busy_o=0.
  - start_i high at edge E0 → ARM; gate_length is captured into G, and G=0 is treated as G=1.
- ARM (edge E1):
  - Clear all per-VFAT counters and overflow flags.
  - Load gate counter with G.
  - Go to COUNT.
- COUNT:
  - Each cycle, counter[v] += hit[v] and gate counter decrements.
  - Exactly G hit samples are accumulated: those derived from sbits present at edges E1..E1+G-1.
  - When the gate counter reaches 1 → LATCH.
- LATCH (one cycle):
  - Copy counters and overflow flags into the latched arrays.
  - done_o=1 this cycle.
  - If continuous_i=1 → ARM; otherwise → IDLE.
  - Latched values change only in LATCH.
- Saturation: a counter at 2^CNT_BITS-1 holds its value and sets its overflow flag. No wrap-around.
- Mask changes take effect on the next stage-1 sample. No re-arm is required.
- start_i while busy is ignored. start_i held high in IDLE after a window restarts immediately (level semantics).
- continuous_i deasserted mid-window: the current window completes, then the FSM returns to IDLE.
- Readout:
  - rate_o/overflow_o are registered from latched[sel_vfat], with 1-cycle latency after sel_vfat changes.
  - sel_vfat >= MXVFATS returns 0/0.
- Total latency from start_i accepted (E0) to done_o: G+2 clocks.

Decomposition:
- Shared package (sbit_monitor_pkg): MXVFATS, MXSBITS, CNT_BITS, GATE_BITS, and state encodings (IDLE=0, ARM=1, COUNT=2, LATCH=3).
- One natural sub-module: sat_counter (CNT_BITS saturating counter with clear, enable, overflow flag), instantiated MXVFATS times.
- FSM, gate counter and readout mux stay in the top.

Test Plan:
1. Constant hits, 1 SEU cycle:
   - Stimulus: VFAT 3 has sbit 0 high continuously, all others zero; gate_length=100; start pulse.
   - Response: done_o at E0+102; rate_o=100 for sel_vfat=3 and 0 for sel_vfat=4; overflow_o=0.
2. Sparse pattern and mask:
   - Stimulus: VFATs 0 and 1 each hit every 4th clock; sbit_mask[1]=1; gate_length=40.
   - Response: VFAT0=10, VFAT1=0.
3. Saturation:
   - Stimulus: CNT_BITS=4, VFAT 5 always hit, gate_length=20.
   - Response: rate=15, overflow_o=1; other VFATs 0/0.
4. Continuous mode:
   - Stimulus: continuous_i=1, gate_length=10, VFAT 7 hits 3 cycles per window; deassert continuous_i during window 3.
   - Response: exactly 3 done_o pulses, 12 clocks apart, each latching 3; then busy_o=0.
5. Reset mid-window:
   - Stimulus: complete a window with VFAT2=50, then start a new window and assert reset_i low at COUNT cycle 5.
   - Response: no done_o; rate_o=0 for all VFATs; FSM in IDLE.
6. Boundary and readout:
   - Stimulus: gate_length=0 with VFAT 0 always hit; then sel_vfat=24.
   - Response: window of 1 clock, rate=1, done_o 3 clocks after start; sel_vfat=24 gives rate_o=0 one cycle later; start during busy is ignored (single done_o).
